// File: rtl/mem_block_streamer.sv
// rtl/mem_block_streamer.sv - block read/write initiator for a two-bank interleaved memory
module mem_block_streamer #(
  parameter int M = 8,
  parameter int K = 11
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         op,
  input  logic [K-1:0] base,
  input  logic [K:0]   len,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] rd_data,
  output logic         rd_valid,
  input  logic         rd_ack,
  input  logic [M-1:0] wr_data,
  input  logic         wr_valid,
  output logic         wr_ack,
  output logic [K-1:0] mem_A,
  output logic [M-1:0] mem_WD,
  output logic         mem_WE,
  input  logic [M-1:0] mem_RA
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t         state, state_nx;
  logic [K-1:0]   addr;
  logic [K:0]     cnt;
  logic           rd_load;
  logic           wr_fire;
  logic           rd_room;

  // Output buffer can take a new word when empty or being drained this cycle.
  assign rd_room = !rd_valid || rd_ack;

  // State register; reset aborts any transfer in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and per-cycle transfer decisions.
  always_comb begin
    state_nx = state;
    rd_load  = 1'b0;
    wr_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0)  state_nx = DONE;
          else if (op)    state_nx = WRITE;
          else            state_nx = READ;
        end
      end
      READ: begin
        rd_load = (cnt != '0) && rd_room;
        if ((cnt == '0) && rd_room) state_nx = DONE;
      end
      WRITE: begin
        wr_fire = wr_valid;
        if (wr_valid && (cnt == {{K{1'b0}}, 1'b1})) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Address/count datapath and the one-entry read buffer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr     <= '0;
      cnt      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        addr <= base;
        cnt  <= len;
      end
      if (rd_load) begin
        rd_data  <= mem_RA;
        rd_valid <= 1'b1;
        addr     <= addr + 1'b1;
        cnt      <= cnt - 1'b1;
      end else if (state == READ && rd_ack) begin
        rd_valid <= 1'b0;
      end
      if (wr_fire) begin
        addr <= addr + 1'b1;
        cnt  <= cnt - 1'b1;
      end
    end
  end

  // Write strobes are gated by reset so they fall the instant reset rises.
  assign wr_ack = (state == WRITE) && !reset;
  assign mem_WE = wr_fire && !reset;
  assign mem_WD = wr_data;
  assign mem_A  = addr;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

endmodule
